// File: rtl/mmio_io_controller.sv
// mmio_io_controller: memory-mapped I/O block for the pipelined CPU.
// Decodes the I/O page selected by addr[DBITS-1:DBITS-4] == IO_PAGE and
// owns the HEX/LEDR/LEDG output registers, synchronised and debounced
// KEY/SW inputs, sticky key-press flags and a programmable interval timer.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   addr, wrData      byte address and store data from the pipeline
//   isLoad, isStore   memory operation in the current cycle
//   rdData            I/O read data, combinational from registered state
//   ioHit             access (load or store) falls in the I/O page
//   memWrtEn          data-memory write enable (store outside the I/O page)
//   KEY, SW           raw pins (KEY active-low)
//   LEDR, LEDG, HEX   registered output values
module mmio_io_controller #(
  parameter int unsigned DBITS           = 32,
  parameter int unsigned KEY_BITS        = 4,
  parameter int unsigned SW_BITS         = 10,
  parameter int unsigned LEDR_BITS       = 10,
  parameter int unsigned LEDG_BITS       = 8,
  parameter int unsigned HEX_BITS        = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter logic [3:0]  IO_PAGE         = 4'hF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DBITS-1:0]     addr,
  input  logic [DBITS-1:0]     wrData,
  input  logic                 isLoad,
  input  logic                 isStore,
  output logic [DBITS-1:0]     rdData,
  output logic                 ioHit,
  output logic                 memWrtEn,
  input  logic [KEY_BITS-1:0]  KEY,
  input  logic [SW_BITS-1:0]   SW,
  output logic [LEDR_BITS-1:0] LEDR,
  output logic [LEDG_BITS-1:0] LEDG,
  output logic [HEX_BITS-1:0]  HEX
);

  localparam logic [7:0] OFF_HEX   = 8'h00;
  localparam logic [7:0] OFF_LEDR  = 8'h04;
  localparam logic [7:0] OFF_LEDG  = 8'h08;
  localparam logic [7:0] OFF_KEY   = 8'h10;
  localparam logic [7:0] OFF_SW    = 8'h14;
  localparam logic [7:0] OFF_FLAGS = 8'h18;
  localparam logic [7:0] OFF_TCNT  = 8'h20;
  localparam logic [7:0] OFF_TLIM  = 8'h24;
  localparam logic [7:0] OFF_TCTL  = 8'h28;

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);

  // ---------------------------------------------------------------- decode
  logic       in_page;
  logic       wr;
  logic       rd_en;
  logic [7:0] off;
  logic       unused_addr;

  assign in_page     = (addr[DBITS-1:DBITS-4] == IO_PAGE);
  assign off         = addr[7:0];
  assign ioHit       = (isLoad | isStore) & in_page;
  assign memWrtEn    = isStore & ~in_page;
  assign wr          = isStore & in_page;
  // A simultaneous store takes priority, so the load returns nothing.
  assign rd_en       = isLoad & ~isStore & in_page;
  assign unused_addr = ^addr[DBITS-5:8];

  logic wr_hex, wr_ledr, wr_ledg, wr_flags, wr_tcnt, wr_tlim, wr_tctl;
  assign wr_hex   = wr && (off == OFF_HEX);
  assign wr_ledr  = wr && (off == OFF_LEDR);
  assign wr_ledg  = wr && (off == OFF_LEDG);
  assign wr_flags = wr && (off == OFF_FLAGS);
  assign wr_tcnt  = wr && (off == OFF_TCNT);
  assign wr_tlim  = wr && (off == OFF_TLIM);
  assign wr_tctl  = wr && (off == OFF_TCTL);

  // ------------------------------------------------------------ input path
  logic [KEY_BITS-1:0] key_sync1, key_sync2, key_samp, key_db, key_db_nxt;
  logic [SW_BITS-1:0]  sw_sync1, sw_sync2, sw_samp, sw_db, sw_db_nxt;
  logic [CW-1:0]       smp_cnt;
  logic                tick;
  logic [KEY_BITS-1:0] key_press;
  logic [KEY_BITS-1:0] flags;

  assign tick = (smp_cnt == CW'(DEBOUNCE_CYCLES - 1));

  // A bit only moves when two consecutive tick samples agree.
  always_comb begin
    key_db_nxt = key_db;
    sw_db_nxt  = sw_db;
    if (tick) begin
      key_db_nxt = (key_sync2 & ~(key_sync2 ^ key_samp)) | (key_db & (key_sync2 ^ key_samp));
      sw_db_nxt  = (sw_sync2 & ~(sw_sync2 ^ sw_samp)) | (sw_db & (sw_sync2 ^ sw_samp));
    end
  end

  // Pins are active-low: a press is a 1 -> 0 transition of the debounced bit.
  assign key_press = key_db & ~key_db_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      key_sync1 <= '1;
      key_sync2 <= '1;
      key_samp  <= '1;
      key_db    <= '1;
      sw_sync1  <= '0;
      sw_sync2  <= '0;
      sw_samp   <= '0;
      sw_db     <= '0;
      smp_cnt   <= '0;
      flags     <= '0;
    end else begin
      key_sync1 <= KEY;
      key_sync2 <= key_sync1;
      sw_sync1  <= SW;
      sw_sync2  <= sw_sync1;
      smp_cnt   <= tick ? '0 : smp_cnt + CW'(1);
      if (tick) begin
        key_samp <= key_sync2;
        sw_samp  <= sw_sync2;
      end
      key_db <= key_db_nxt;
      sw_db  <= sw_db_nxt;
      // Set is ORed in after the clear so a same-cycle press survives.
      flags  <= (flags & ~(wr_flags ? wrData[KEY_BITS-1:0] : '0)) | key_press;
    end
  end

  // ------------------------------------------------------- output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      HEX  <= '0;
      LEDR <= '0;
      LEDG <= '0;
    end else begin
      if (wr_hex)  HEX  <= wrData[HEX_BITS-1:0];
      if (wr_ledr) LEDR <= wrData[LEDR_BITS-1:0];
      if (wr_ledg) LEDG <= wrData[LEDG_BITS-1:0];
    end
  end

  // ------------------------------------------------------------------ timer
  logic [DBITS-1:0] tcount, tlimit;
  logic             ten, tready;
  logic             tmatch;

  assign tmatch = (tcount == tlimit);

  always_ff @(posedge clk) begin
    if (reset) begin
      tcount <= '0;
      tlimit <= '0;
      ten    <= 1'b0;
      tready <= 1'b0;
    end else begin
      if (wr_tcnt)  tcount <= wrData;
      else if (ten) tcount <= tmatch ? '0 : tcount + DBITS'(1);
      if (wr_tlim)  tlimit <= wrData;
      if (wr_tctl)  ten    <= wrData[0];
      tready <= (tready & ~(wr_tctl & wrData[1])) | (ten & tmatch);
    end
  end

  // -------------------------------------------------------------- read mux
  logic [DBITS-1:0] rd_val;

  always_comb begin
    rd_val = '0;
    case (off)
      OFF_HEX:   rd_val[HEX_BITS-1:0]  = HEX;
      OFF_LEDR:  rd_val[LEDR_BITS-1:0] = LEDR;
      OFF_LEDG:  rd_val[LEDG_BITS-1:0] = LEDG;
      OFF_KEY:   rd_val[KEY_BITS-1:0]  = ~key_db;
      OFF_SW:    rd_val[SW_BITS-1:0]   = sw_db;
      OFF_FLAGS: rd_val[KEY_BITS-1:0]  = flags;
      OFF_TCNT:  rd_val                = tcount;
      OFF_TLIM:  rd_val                = tlimit;
      OFF_TCTL:  rd_val[1:0]           = {tready, ten};
      default:   rd_val                = '0;
    endcase
  end

  assign rdData = rd_en ? rd_val : '0;

endmodule
